// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : alu_pkg                                                  |
// | Brief    : shared encodings for param_accum_alu and its multiplier  |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
package alu_pkg;

   localparam logic [1:0] c_st_off     = 2'b00;
   localparam logic [1:0] c_st_ready   = 2'b01;
   localparam logic [1:0] c_st_running = 2'b10;
   localparam logic [1:0] c_st_error   = 2'b11;

   localparam int c_op_and = 0;
   localparam int c_op_or  = 1;
   localparam int c_op_xor = 2;
   localparam int c_op_not = 3;
   localparam int c_op_add = 4;
   localparam int c_op_sub = 5;
   localparam int c_op_mul = 6;

   localparam logic [6:0] c_sel_and = 7'b000_0001;
   localparam logic [6:0] c_sel_or  = 7'b000_0010;
   localparam logic [6:0] c_sel_xor = 7'b000_0100;
   localparam logic [6:0] c_sel_not = 7'b000_1000;
   localparam logic [6:0] c_sel_add = 7'b001_0000;
   localparam logic [6:0] c_sel_sub = 7'b010_0000;
   localparam logic [6:0] c_sel_mul = 7'b100_0000;

   localparam logic [2:0] c_in_persist = 3'b001;
   localparam logic [2:0] c_in_load    = 3'b010;
   localparam logic [2:0] c_in_reset   = 3'b100;

   localparam int c_err_ovf     = 0;
   localparam int c_err_borrow  = 1;
   localparam int c_err_illegal = 2;

   function automatic logic is_onehot(input logic [6:0] v);
      return (v != 7'd0) && ((v & (v - 7'd1)) == 7'd0);
   endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/seq_mult.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : seq_mult                                                 |
// | Brief    : unsigned shift-add multiplier, one multiplier bit/cycle   |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module seq_mult #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 abort,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int c_cnt_w = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_prod;
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_busy;
   logic [2*WIDTH-1:0] w_prod_next;

   assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);

   // product is the running sum including this cycle's partial, so it is
   // final during the cycle that done is high
   assign product = w_prod_next;
   assign busy    = r_busy;
   assign done    = r_busy && (r_cnt == c_cnt_w'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
      end else if (abort) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
      end else if (start) begin
         r_busy   <= 1'b1;
         r_cnt    <= c_cnt_w'(WIDTH);
         r_mcand  <= {{WIDTH{1'b0}}, a};
         r_mplier <= b;
         r_prod   <= '0;
      end else if (r_busy) begin
         r_prod   <= w_prod_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt - c_cnt_w'(1);
         if (r_cnt == c_cnt_w'(1)) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule : seq_mult
`default_nettype wire

// File: rtl/param_accum_alu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : param_accum_alu                                          |
// | Brief    : accumulating ALU with handshake, FSM and sequential MUL   |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module param_accum_alu
   import alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             on,
   input  logic [2:0]       in_sel,
   input  logic [WIDTH-1:0] num1,
   input  logic [WIDTH-1:0] num2,
   input  logic [6:0]       out_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic [2:0]       err,
   output logic [1:0]       curr_state,
   output logic [1:0]       next_state
);

   logic [1:0]         r_state;
   logic [WIDTH-1:0]   r_out;
   logic [2:0]         r_err;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [6:0]         r_op;

   logic               w_accept;
   logic               w_sel_reset;
   logic               w_illegal;
   logic [WIDTH-1:0]   w_operand_a;
   logic               w_mul_start;
   logic               w_mul_busy;
   logic               w_mul_done;
   logic [2*WIDTH-1:0] w_product;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH-1:0]   w_diff;
   logic               w_borrow;
   logic               w_complete;
   logic [WIDTH-1:0]   w_result;
   logic [2:0]         w_flags;
   logic [1:0]         w_next_state;

   assign in_ready   = (r_state == c_st_ready) && !w_mul_busy;
   assign out        = r_out;
   assign out_valid  = r_out_valid;
   assign err        = r_err;
   assign curr_state = r_state;
   assign next_state = w_next_state;

   assign w_accept    = in_valid && in_ready && on;
   assign w_sel_reset = (in_sel == c_in_reset);
   assign w_illegal   = !is_onehot({4'b0000, in_sel}) || !is_onehot(out_sel)
                        || (out_sel[c_op_mul] && !MUL_EN);
   // the accumulator and the visible result are the same register
   assign w_operand_a = in_sel[1] ? num1 : r_out;
   assign w_mul_start = w_accept && !w_sel_reset && !w_illegal && out_sel[c_op_mul];

   generate
      if (MUL_EN) begin : g_mult
         seq_mult #(
            .WIDTH (WIDTH)
         ) u_seq_mult (
            .clk     (clk),
            .rst     (rst),
            .abort   (!on),
            .start   (w_mul_start),
            .a       (w_operand_a),
            .b       (num2),
            .busy    (w_mul_busy),
            .done    (w_mul_done),
            .product (w_product)
         );
      end else begin : g_no_mult
         assign w_mul_busy = 1'b0;
         assign w_mul_done = 1'b0;
         assign w_product  = '0;
      end
   endgenerate

   assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
   assign w_diff   = r_a - r_b;
   assign w_borrow = (r_a < r_b);

   always_comb begin
      w_complete = 1'b0;
      w_result   = '0;
      w_flags    = '0;
      if (r_state == c_st_running) begin
         if (r_op[c_op_mul]) begin
            w_complete         = w_mul_done;
            w_result           = w_product[WIDTH-1:0];
            w_flags[c_err_ovf] = |w_product[2*WIDTH-1:WIDTH];
         end else begin
            w_complete = 1'b1;
            if (r_op[c_op_add]) begin
               w_result           = w_sum[WIDTH-1:0];
               w_flags[c_err_ovf] = w_sum[WIDTH];
            end else if (r_op[c_op_sub]) begin
               w_result              = w_diff;
               w_flags[c_err_borrow] = w_borrow;
            end else if (r_op[c_op_not]) begin
               w_result = ~r_a;
            end else if (r_op[c_op_xor]) begin
               w_result = r_a ^ r_b;
            end else if (r_op[c_op_or]) begin
               w_result = r_a | r_b;
            end else begin
               w_result = r_a & r_b;
            end
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (!on) begin
         w_next_state = c_st_off;
      end else begin
         case (r_state)
            c_st_off: w_next_state = c_st_ready;
            c_st_ready: begin
               if (w_accept && !w_sel_reset) begin
                  w_next_state = w_illegal ? c_st_error : c_st_running;
               end
            end
            c_st_running: begin
               if (w_complete) begin
                  w_next_state = (w_flags != 3'b000) ? c_st_error : c_st_ready;
               end
            end
            default: w_next_state = c_st_ready;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= c_st_off;
         r_out       <= '0;
         r_err       <= '0;
         r_out_valid <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= '0;
      end else begin
         r_state     <= w_next_state;
         r_out_valid <= 1'b0;
         if (on) begin
            if (w_accept) begin
               if (w_sel_reset) begin
                  r_out <= '0;
                  r_err <= '0;
               end else if (w_illegal) begin
                  r_err <= 3'b100;
               end else begin
                  r_a   <= w_operand_a;
                  r_b   <= num2;
                  r_op  <= out_sel;
                  r_err <= '0;
               end
            end
            if (w_complete) begin
               r_out       <= w_result;
               r_err       <= w_flags;
               r_out_valid <= 1'b1;
            end
         end
      end
   end

endmodule : param_accum_alu
`default_nettype wire

// File: tb/tb_param_accum_alu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_param_accum_alu                                       |
// | Brief    : directed scoreboard bench for param_accum_alu (WIDTH=8)  |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_param_accum_alu;
   import alu_pkg::*;

   typedef struct {
      logic [7:0] out;
      logic [2:0] err;
      int         lat;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst, on, in_valid, in_ready, out_valid;
   logic [2:0] in_sel, err;
   logic [7:0] num1, num2, out;
   logic [6:0] out_sel;
   logic [1:0] curr_state, next_state;

   exp_t       sb[$];
   int         tests = 0;
   int         fails = 0;
   logic [7:0] m_acc = 8'd0;

   param_accum_alu #(.WIDTH(8), .MUL_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .on(on), .in_sel(in_sel), .num1(num1), .num2(num2),
      .out_sel(out_sel), .in_valid(in_valid), .in_ready(in_ready), .out(out),
      .out_valid(out_valid), .err(err), .curr_state(curr_state), .next_state(next_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // reference arithmetic in plain integers; returns {err, out}
   function automatic logic [10:0] model(input int a, input int b, input logic [6:0] op);
      int         r;
      logic [2:0] e;
      e = 3'b000;
      r = 0;
      if (op == c_sel_mul) begin
         r = a * b;
         if (r > 255) e[0] = 1'b1;
      end else if (op == c_sel_add) begin
         r = a + b;
         if (r > 255) e[0] = 1'b1;
      end else if (op == c_sel_sub) begin
         r = a - b + 256;
         if (a < b) e[1] = 1'b1;
      end else if (op == c_sel_not) begin
         r = 255 - a;
      end else if (op == c_sel_xor) begin
         r = a ^ b;
      end else if (op == c_sel_or) begin
         r = a | b;
      end else begin
         r = a & b;
      end
      return {e, 8'(r % 256)};
   endfunction

   task automatic run_op(input logic [2:0] isel, input logic [7:0] n1, input logic [7:0] n2,
                         input logic [6:0] osel, input string tag);
      int         a;
      int         lat;
      logic [10:0] m;
      exp_t       e;
      exp_t       got;
      a   = (isel == c_in_load) ? int'(n1) : int'(m_acc);
      m   = model(a, int'(n2), osel);
      e.out = m[7:0];
      e.err = m[10:8];
      e.lat = (osel == c_sel_mul) ? 8 : 1;
      sb.push_back(e);
      m_acc = m[7:0];

      in_sel = isel; num1 = n1; num2 = n2; out_sel = osel; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      num1 = 8'hA5; num2 = 8'h5A;
      check({tag, "_running"}, 16'(curr_state), 16'(c_st_running));
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!out_valid && lat < 40);
      check({tag, "_out_valid"}, 16'(out_valid), 16'd1);
      if (sb.size() > 0) begin
         got = sb.pop_front();
         if (out_valid) begin
            check({tag, "_out"}, 16'(out), 16'(got.out));
            check({tag, "_err"}, 16'(err), 16'(got.err));
            check({tag, "_latency"}, 16'(lat), 16'(got.lat));
            check({tag, "_state"}, 16'(curr_state),
                  16'((got.err != 3'b000) ? c_st_error : c_st_ready));
            if (got.err != 3'b000) begin
               tick();
               check({tag, "_err_to_ready"}, 16'(curr_state), 16'(c_st_ready));
               check({tag, "_err_held"}, 16'(err), 16'(got.err));
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; on = 1'b0; in_valid = 1'b0; in_sel = 3'b000;
      num1 = 8'd0; num2 = 8'd0; out_sel = 7'd0;
      tick(); tick();
      check("rst_state", 16'(curr_state), 16'(c_st_off));
      check("rst_out", 16'(out), 16'd0);
      check("rst_err", 16'(err), 16'd0);
      check("rst_out_valid", 16'(out_valid), 16'd0);
      check("rst_in_ready", 16'(in_ready), 16'd0);

      // power up, power down from READY, power up again
      rst = 1'b0; on = 1'b1;
      #1;
      check("off_next_state", 16'(next_state), 16'(c_st_ready));
      tick();
      check("ready_state", 16'(curr_state), 16'(c_st_ready));
      check("ready_in_ready", 16'(in_ready), 16'd1);
      on = 1'b0;
      #1;
      check("ready_next_off", 16'(next_state), 16'(c_st_off));
      tick();
      check("off_again", 16'(curr_state), 16'(c_st_off));
      on = 1'b1;
      tick();

      run_op(c_in_load, 8'd3, 8'd2, c_sel_mul, "mul_3x2");
      check("mul_3x2_const", 16'(out), 16'd6);
      run_op(c_in_load, 8'd87, 8'd26, c_sel_mul, "mul_87x26");
      check("mul_87x26_const", 16'(out), 16'h00D6);
      run_op(c_in_load, 8'd2, 8'd4, c_sel_sub, "sub_2m4");
      check("sub_2m4_const", 16'(out), 16'h00FE);
      run_op(c_in_persist, 8'd0, 8'd3, c_sel_add, "add_carry");
      check("add_carry_const", 16'(out), 16'h0001);

      // accumulator clear: no result pulse
      in_sel = c_in_reset; out_sel = c_sel_add; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      m_acc = 8'd0;
      check("accclr_out", 16'(out), 16'd0);
      check("accclr_valid", 16'(out_valid), 16'd0);
      check("accclr_err", 16'(err), 16'd0);
      check("accclr_state", 16'(curr_state), 16'(c_st_ready));

      run_op(c_in_persist, 8'd77, 8'd9, c_sel_add, "persist_add");
      run_op(c_in_load, 8'd50, 8'd25, c_sel_xor, "xor");
      run_op(c_in_load, 8'd50, 8'd25, c_sel_or, "or");
      run_op(c_in_load, 8'd50, 8'd25, c_sel_and, "and");
      run_op(c_in_load, 8'd129, 8'd77, c_sel_not, "not");
      run_op(c_in_persist, 8'd0, 8'd200, c_sel_mul, "mul_persist");
      run_op(c_in_load, 8'd126, 8'd0, c_sel_and, "restore");

      // illegal op select
      in_sel = c_in_load; num1 = 8'd1; num2 = 8'd1; out_sel = 7'b000_0011; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("illegal_state", 16'(curr_state), 16'(c_st_error));
      check("illegal_err", 16'(err), 16'b100);
      check("illegal_out", 16'(out), 16'd0);
      check("illegal_valid", 16'(out_valid), 16'd0);
      tick();
      check("illegal_to_ready", 16'(curr_state), 16'(c_st_ready));

      // MUL aborted by power-off mid-flight
      in_sel = c_in_load; num1 = 8'd3; num2 = 8'd5; out_sel = c_sel_mul; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      on = 1'b0;
      tick();
      check("abort_state", 16'(curr_state), 16'(c_st_off));
      check("abort_valid", 16'(out_valid), 16'd0);
      check("abort_out", 16'(out), 16'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("abort_quiet", 16'(out_valid), 16'd0);
      end
      on = 1'b1;
      tick();
      check("abort_ready", 16'(curr_state), 16'(c_st_ready));
      check("abort_out_held", 16'(out), 16'd0);
      check("sb_empty", 16'(sb.size()), 16'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_param_accum_alu
`default_nettype wire
